// File: rtl/temp_report_seq_pkg.sv
// Shared types and constants for the periodic temperature report scheduler.
package temp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        MEASURE,
        SEND
    } state_e;

    localparam logic [2:0] IDX_SYNC = 3'd0;
    localparam logic [2:0] IDX_SEQ  = 3'd1;
    localparam logic [2:0] IDX_HI   = 3'd2;
    localparam logic [2:0] IDX_LO   = 3'd3;
    localparam logic [2:0] IDX_CHK  = 3'd4;
    localparam int unsigned FRAME_LEN = 5;

    // Substituted for the measurement when the sensor never answers.
    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/temp_report_seq_if.sv
// Measurement-request and UART TX byte handshakes seen by the scheduler.
interface temp_report_seq_if;
    logic        meas_start_o;
    logic        meas_done_i;
    logic [15:0] meas_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;

    modport master (
        output meas_start_o, tx_valid_o, tx_data_o,
        input  meas_done_i, meas_data_i, tx_ready_i
    );

    modport slave (
        input  meas_start_o, tx_valid_o, tx_data_o,
        output meas_done_i, meas_data_i, tx_ready_i
    );
endinterface

// File: rtl/temp_report_seq_tick_gen.sv
// Report period counter: tick_o pulses on the terminal count, counter held at zero while disabled.
module sched_tick_gen #(
    parameter int unsigned PERIOD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    output logic tick_o
);
    localparam int unsigned CW = $clog2(PERIOD_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == CW'(PERIOD_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/temp_report_seq.sv
// Periodic scheduler: request a measurement, then push a 5-byte framed report to UART TX.
// reset_n asserts asynchronously; its release is expected to be synchronised upstream.
module temp_report_seq
    import temp_seq_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MEAS_TIMEOUT  = 65535,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    temp_report_seq_if.master bus,
    output logic              busy_o,
    output logic [7:0]        err_cnt_o
);
    localparam int unsigned TW = $clog2(MEAS_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [2:0]    idx_q, idx_d, idx_nxt;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    byte_q, byte_d, nxt_byte;
    logic [15:0]   data_q, data_d;
    logic          tick;

    sched_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable_i(enable_i),
        .tick_o  (tick)
    );

    // Byte that follows the one currently presented; loaded into byte_q on handshake.
    assign idx_nxt = idx_q + 3'd1;
    always_comb begin
        nxt_byte = SYNC_BYTE;
        case (idx_nxt)
            IDX_SEQ: nxt_byte = seq_q;
            IDX_HI:  nxt_byte = data_q[15:8];
            IDX_LO:  nxt_byte = data_q[7:0];
            IDX_CHK: nxt_byte = seq_q ^ data_q[15:8] ^ data_q[7:0];
            default: nxt_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tout_d  = tout_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        err_d   = err_q;
        byte_d  = byte_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (tick && enable_i) state_d = START;
            START: begin
                tout_d  = '0;
                state_d = MEASURE;
            end
            MEASURE: begin
                // A done arriving on the expiry cycle still counts as a real measurement.
                if (bus.meas_done_i) begin
                    data_d  = bus.meas_data_i;
                    idx_d   = IDX_SYNC;
                    byte_d  = SYNC_BYTE;
                    state_d = SEND;
                end else if (tout_q == TW'(MEAS_TIMEOUT - 1)) begin
                    data_d  = TIMEOUT_DATA;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    idx_d   = IDX_SYNC;
                    byte_d  = SYNC_BYTE;
                    state_d = SEND;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            SEND: begin
                if (bus.tx_ready_i) begin
                    if (idx_q == IDX_CHK) begin
                        seq_d   = seq_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_nxt;
                        byte_d = nxt_byte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tout_q  <= '0;
            idx_q   <= IDX_SYNC;
            seq_q   <= '0;
            err_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tout_q  <= tout_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
        end
    end

    // Decoded straight from state_q so both strobes drop with the async reset.
    assign bus.meas_start_o = (state_q == START);
    assign bus.tx_valid_o   = (state_q == SEND);
    assign bus.tx_data_o    = byte_q;
    assign busy_o           = (state_q != IDLE);
    assign err_cnt_o        = err_q;
endmodule
